branch_identify_q: RTL and testbench
====================================

# branch_identify_q

Queued, parametrised successor to the single-word branch identifier. Accepts a stream of 32-bit Power ISA instruction words with a valid/ready handshake, pairs prefixed (8-byte) instructions, classifies each instruction for the branch unit and buffers the results in a DEPTH-entry FIFO. The FIFO drains to the branch unit through a second valid/ready handshake. It sits between fetch and the branch unit and decouples fetch from branch-unit back-pressure.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  global enable; when low, no push, no pop, and all state holds.
- i_flush  in  1  synchronous flush; empties FIFO and clears prefix state.
- i_valid  in  1  i_word is valid.
- i_word  in  [0:31]  instruction word, IBM bit order, opcode in bits 0:5.
- o_ready  out  1  i_en && !full && !i_flush; combinational.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  branch unit accepts the head entry.
- o_instr  out  [0:63]  head instruction; a non-prefixed word sits in bits 0:31 with bits 32:63 zero.
- o_prefixed  out  1  head is a prefix+suffix pair.
- o_bu_en  out  1  head is a branch.
- o_bu_i_form, o_bu_b_form, o_bu_cond_LR, o_bu_cond_CTR, o_bu_cond_TAR  out  1 each  one-hot branch class, all zero when o_bu_en is 0.
- o_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Classification of a single word w:
  - opcode 18 -> I-form.
  - opcode 16 -> B-form.
  - opcode 19 with XO (bits 21:30) = 16 -> cond_LR; XO = 528 -> cond_CTR; XO = 560 -> cond_TAR.
  - Any other word is a non-branch, and all class bits are 0.
- Push: occurs on i_valid && o_ready.
- Prefix FSM with two states, IDLE and PREFIX:
  - IDLE + pushed word with opcode 1 -> store the word in the prefix register, go to PREFIX, no FIFO write.
  - IDLE + any other pushed word -> write the classified entry.
  - PREFIX + pushed word -> write {prefix, word} with o_prefixed=1 and o_bu_en=0, then return to IDLE. The suffix is never classified.
  - o_ready is not gated by the FSM state.
- Pop: occurs on o_valid && i_ready && i_en.
- Full boundary: o_ready does not depend on i_ready, so a full FIFO rejects input in the same cycle as a pop.
- Empty boundary: an entry pushed into an empty FIFO appears on o_valid the next cycle; there is no bypass.
- Simultaneous push and pop: o_count is unchanged.
- Pointers: wrap modulo DEPTH.
- i_flush:
  - Takes priority over push and pop.
  - Next edge: o_count=0, FSM=IDLE, prefix register cleared.
- Reset values: all outputs 0 except o_ready, which is i_en (full=0 under reset); FSM=IDLE; pointers 0.
- Reset mid-prefix: any pending prefix is discarded.

## Timing
- Latency: 1 cycle from push edge to o_valid/o_instr; 2 cycles for a prefixed pair, counted from the prefix push.
- Outputs o_instr, o_prefixed and o_bu_* are taken from a registered FIFO head and are stable while o_valid && !i_ready.
- Throughput: 1 instruction per cycle sustained; 1 pair per 2 cycles.
- i_en low: o_ready=0, no pop, FSM and FIFO frozen.

## Configuration
- Macro: BRANCH_IDENTIFY_PREFIX_EN.
- Defined: the prefix FSM operates as described above.
- Undefined: there is no PREFIX state, and opcode 1 is written as a non-branch single word with o_prefixed=0.

## Structure
- Package identify_pkg holds:
  - opcode constants OP_PREFIX=1, OP_BC=16, OP_B=18, OP_XL=19.
  - XO constants XO_BCLR=16, XO_BCCTR=528, XO_BCTAR=560.
  - a packed struct id_entry_t {instr[0:63], prefixed, bu_en, i_form, b_form, cond_lr, cond_ctr, cond_tar}.
  - a pure classify function.
- Sub-module identify_fifo: generic DEPTH x id_entry_t synchronous FIFO with flush and count. The top level contains the FSM, classification and the o_ready logic.

## Test plan
- Push 0x48032BFB -> next cycle o_valid=1, o_bu_en=1, o_bu_i_form=1, other class bits 0, o_instr=0x48032BFB_00000000.
- Push 0x4182000C, 0x4E800020, 0x4E800420, 0x4E800460, 0x38600001 back to back with i_ready=1 -> heads in order: B-form, LR, CTR, TAR, then non-branch (o_bu_en=0).
- Push 0x04000000 then 0x38600001 -> one entry with o_prefixed=1, o_instr=0x04000000_38600001, o_bu_en=0, o_count peaks at 1. Without the macro: two entries.
- Fill with i_ready=0, DEPTH=4 -> o_count=4, o_ready=0. Assert i_ready and i_valid together -> only the pop occurs, o_count=3, then the push resumes.
- Push a prefix, then assert i_flush -> o_count=0 next cycle. A subsequent 0x4E800020 is classified cond_LR, not paired.
- Assert i_rst asynchronously mid-stream -> all outputs 0 immediately, o_count=0, FSM=IDLE.

Source files
------------

// File: rtl/identify_pkg.sv
// identify_pkg: Power ISA branch opcodes, queue entry layout and the single-word classifier.
package identify_pkg;

    localparam logic [5:0] OP_PREFIX = 6'd1;
    localparam logic [5:0] OP_BC     = 6'd16;
    localparam logic [5:0] OP_B      = 6'd18;
    localparam logic [5:0] OP_XL     = 6'd19;

    localparam logic [9:0] XO_BCLR  = 10'd16;
    localparam logic [9:0] XO_BCCTR = 10'd528;
    localparam logic [9:0] XO_BCTAR = 10'd560;

    typedef struct packed {
        logic [0:63] instr;
        logic        prefixed;
        logic        bu_en;
        logic        i_form;
        logic        b_form;
        logic        cond_lr;
        logic        cond_ctr;
        logic        cond_tar;
    } id_entry_t;

    function automatic id_entry_t classify(input logic [0:31] w);
        logic [5:0] op;
        logic [9:0] xo;
        id_entry_t  e;
        op         = w[0:5];
        xo         = w[21:30];
        e          = '0;
        e.instr    = {w, 32'h0};
        e.i_form   = op == OP_B;
        e.b_form   = op == OP_BC;
        e.cond_lr  = op == OP_XL && xo == XO_BCLR;
        e.cond_ctr = op == OP_XL && xo == XO_BCCTR;
        e.cond_tar = op == OP_XL && xo == XO_BCTAR;
        e.bu_en    = e.i_form | e.b_form | e.cond_lr | e.cond_ctr | e.cond_tar;
        return e;
    endfunction

endpackage

// File: rtl/identify_fifo.sv
// identify_fifo: DEPTH-entry id_entry_t FIFO with flush and occupancy; head reads as zero when empty.
module identify_fifo
    import identify_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  id_entry_t              i_data,
    output id_entry_t              o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    id_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign o_full  = count == FULL_CNT;
    assign o_empty = count == '0;
    assign o_count = count;
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk)
        if (i_push && !i_flush)
            mem[wr_ptr] <= i_data;

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(i_push) - (AW + 1)'(i_pop);
        end
    end

endmodule

// File: rtl/branch_identify_q.sv
// branch_identify_q: classifies fetched instruction words for the branch unit and queues them.
// Prefixed-pair joining is built only when BRANCH_IDENTIFY_PREFIX_EN is defined.
module branch_identify_q
    import identify_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [0:31]            i_word,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [0:63]            o_instr,
    output logic                   o_prefixed,
    output logic                   o_bu_en,
    output logic                   o_bu_i_form,
    output logic                   o_bu_b_form,
    output logic                   o_bu_cond_LR,
    output logic                   o_bu_cond_CTR,
    output logic                   o_bu_cond_TAR,
    output logic [$clog2(DEPTH):0] o_count
);

    id_entry_t wr_data, head;
    logic      full, empty, push, pop, wr_en;

    // Back-pressure ignores i_ready: a full queue refuses input even while it pops.
    assign o_ready = i_en && !full && !i_flush;
    assign push    = i_valid && o_ready;
    assign pop     = !empty && i_ready && i_en;

`ifdef BRANCH_IDENTIFY_PREFIX_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_PREFIX = 1'b1;

    logic [0:0]  state;
    logic [0:31] prefix;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            prefix <= '0;
        end else if (i_en && i_flush) begin
            state  <= ST_IDLE;
            prefix <= '0;
        end else if (push) begin
            if (state == ST_IDLE && i_word[0:5] == OP_PREFIX) begin
                state  <= ST_PREFIX;
                prefix <= i_word;
            end else begin
                state  <= ST_IDLE;
            end
        end
    end

    // The suffix is carried verbatim; a pair is never handed to the branch unit as a branch.
    always_comb begin
        wr_data = classify(i_word);
        if (state == ST_PREFIX) begin
            wr_data          = '0;
            wr_data.instr    = {prefix, i_word};
            wr_data.prefixed = 1'b1;
        end
    end

    assign wr_en = push && !(state == ST_IDLE && i_word[0:5] == OP_PREFIX);
`else
    assign wr_data = classify(i_word);
    assign wr_en   = push;
`endif

    identify_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush && i_en),
        .i_push  (wr_en),
        .i_pop   (pop),
        .i_data  (wr_data),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (o_count)
    );

    assign o_valid       = !empty;
    assign o_instr       = head.instr;
    assign o_prefixed    = head.prefixed;
    assign o_bu_en       = head.bu_en;
    assign o_bu_i_form   = head.i_form;
    assign o_bu_b_form   = head.b_form;
    assign o_bu_cond_LR  = head.cond_lr;
    assign o_bu_cond_CTR = head.cond_ctr;
    assign o_bu_cond_TAR = head.cond_tar;

endmodule

// File: tb/tb_branch_identify_q.sv
// tb_branch_identify_q: queue-level reference model checked every cycle, plus directed literal checks.
module tb_branch_identify_q;

    localparam int DEPTH = 4;

    logic        i_clk = 0, i_rst = 1, i_en = 1, i_flush = 0, i_valid = 0, i_ready = 0;
    logic [0:31] i_word = '0;
    logic        o_ready, o_valid, o_prefixed, o_bu_en;
    logic        o_bu_i_form, o_bu_b_form, o_bu_cond_LR, o_bu_cond_CTR, o_bu_cond_TAR;
    logic [0:63] o_instr;
    logic [2:0]  o_count;

    int checks = 0, errors = 0;

    branch_identify_q #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
        .i_valid(i_valid), .i_word(i_word), .o_ready(o_ready), .o_valid(o_valid),
        .i_ready(i_ready), .o_instr(o_instr), .o_prefixed(o_prefixed), .o_bu_en(o_bu_en),
        .o_bu_i_form(o_bu_i_form), .o_bu_b_form(o_bu_b_form), .o_bu_cond_LR(o_bu_cond_LR),
        .o_bu_cond_CTR(o_bu_cond_CTR), .o_bu_cond_TAR(o_bu_cond_TAR), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of expected entries; class order {i, b, lr, ctr, tar}.
    typedef struct {
        logic [63:0] instr;
        bit          pre;
        logic [4:0]  cls;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    bit          mpend;
    logic [31:0] mpre;
    bit          acc;

    function automatic logic [4:0] mcls(input logic [31:0] w);
        int unsigned op = w >> 26;
        int unsigned xo = (w >> 1) & 32'h3FF;
        if (op == 18) return 5'b10000;
        if (op == 16) return 5'b01000;
        if (op == 19 && xo == 16) return 5'b00100;
        if (op == 19 && xo == 528) return 5'b00010;
        if (op == 19 && xo == 560) return 5'b00001;
        return 5'b00000;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q.delete();
            mpend = 0;
        end else if (i_en) begin
            if (i_flush) begin
                q.delete();
                mpend = 0;
            end else begin
                acc = i_valid && q.size() < DEPTH;
                if (q.size() > 0 && i_ready)
                    void'(q.pop_front());
                if (acc) begin
                    if (mpend) begin
                        e.instr = {mpre, i_word};
                        e.pre   = 1;
                        e.cls   = 0;
                        q.push_back(e);
                        mpend = 0;
`ifdef BRANCH_IDENTIFY_PREFIX_EN
                    end else if ((i_word >> 26) == 1) begin
                        mpend = 1;
                        mpre  = i_word;
`endif
                    end else begin
                        e.instr = {i_word, 32'h0};
                        e.pre   = 0;
                        e.cls   = mcls(i_word);
                        q.push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge i_clk) begin
        chk("count", 64'(o_count), 64'(q.size()));
        chk("valid", 64'(o_valid), 64'(q.size() > 0));
        chk("ready", 64'(o_ready), 64'(i_en && q.size() < DEPTH && !i_flush));
        if (q.size() > 0) begin
            chk("head_instr", o_instr, q[0].instr);
            chk("head_prefixed", 64'(o_prefixed), 64'(q[0].pre));
            chk("head_bu_en", 64'(o_bu_en), 64'(|q[0].cls));
            chk("head_class", 64'({o_bu_i_form, o_bu_b_form, o_bu_cond_LR, o_bu_cond_CTR, o_bu_cond_TAR}),
                64'(q[0].cls));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] w, input logic r);
        i_valid = v;
        i_word  = w;
        i_ready = r;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        i_rst = 0;

        cyc(1, 32'h48032BFB, 0);
        chk("iform_valid", 64'(o_valid), 64'd1);
        chk("iform_bu_en", 64'(o_bu_en), 64'd1);
        chk("iform_class", 64'({o_bu_i_form, o_bu_b_form, o_bu_cond_LR, o_bu_cond_CTR, o_bu_cond_TAR}), 64'b10000);
        chk("iform_instr", o_instr, 64'h48032BFB_00000000);
        cyc(0, 0, 1);
        chk("drain1", 64'(o_count), 64'd0);

        cyc(1, 32'h4182000C, 1);
        chk("bform", 64'(o_bu_b_form), 64'd1);
        cyc(1, 32'h4E800020, 1);
        chk("lr", 64'(o_bu_cond_LR), 64'd1);
        cyc(1, 32'h4E800420, 1);
        chk("ctr", 64'(o_bu_cond_CTR), 64'd1);
        cyc(1, 32'h4E800460, 1);
        chk("tar", 64'(o_bu_cond_TAR), 64'd1);
        cyc(1, 32'h38600001, 1);
        chk("nonbr_bu_en", 64'(o_bu_en), 64'd0);
        chk("nonbr_count", 64'(o_count), 64'd1);
        cyc(0, 0, 1);

        cyc(1, 32'h04000000, 0);
        cyc(1, 32'h38600001, 0);
`ifdef BRANCH_IDENTIFY_PREFIX_EN
        chk("pair_count", 64'(o_count), 64'd1);
        chk("pair_instr", o_instr, 64'h04000000_38600001);
        chk("pair_prefixed", 64'(o_prefixed), 64'd1);
        chk("pair_bu_en", 64'(o_bu_en), 64'd0);
`else
        chk("noprefix_count", 64'(o_count), 64'd2);
        chk("noprefix_prefixed", 64'(o_prefixed), 64'd0);
        chk("noprefix_instr", o_instr, 64'h04000000_00000000);
`endif
        cyc(0, 0, 1);
        cyc(0, 0, 1);

        for (int k = 0; k < 4; k++) cyc(1, 32'h38600010 + k, 0);
        chk("full_count", 64'(o_count), 64'd4);
        chk("full_ready", 64'(o_ready), 64'd0);
        cyc(1, 32'h48000100, 1);
        chk("full_pop_only", 64'(o_count), 64'd3);
        cyc(1, 32'h48000100, 1);
        chk("pushpop_count", 64'(o_count), 64'd3);
        repeat (4) cyc(0, 0, 1);

        cyc(1, 32'h04000000, 0);
        i_flush = 1;
        cyc(1, 32'h4E800020, 0);
        chk("flush_count", 64'(o_count), 64'd0);
        i_flush = 0;
        cyc(1, 32'h4E800020, 0);
        chk("postflush_lr", 64'(o_bu_cond_LR), 64'd1);
        chk("postflush_prefixed", 64'(o_prefixed), 64'd0);

        i_en = 0;
        cyc(1, 32'h48000000, 1);
        chk("en_hold_count", 64'(o_count), 64'd1);
        chk("en_ready", 64'(o_ready), 64'd0);
        i_en = 1;
        cyc(0, 0, 1);

        cyc(1, 32'h48032BFB, 0);
        cyc(1, 32'h04000000, 0);
        #2;
        i_rst = 1;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        chk("arst_instr", o_instr, 64'd0);
        chk("arst_bu_en", 64'(o_bu_en), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 0;
        cyc(1, 32'h38600001, 0);
        chk("after_rst_count", 64'(o_count), 64'd1);
        chk("after_rst_instr", o_instr, 64'h38600001_00000000);
        chk("after_rst_prefixed", 64'(o_prefixed), 64'd0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
